port_requester: RTL

- Input-port-side requester for the 16x16 crosspoint router; the initiator end of the per-output fixed-priority arbiter handshake.
- Buffers incoming bytes in a local FIFO and decodes the destination from each packet's header byte.
- Raises the request line toward the destination output's arbiter, waits for that arbiter's grant, and streams the packet through the crosspoint.
- Releases the request at end of packet so the arbiter can re-arbitrate.

---
 rtl/port_requester.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/port_requester.sv
// Input-port requester for the 16x16 crosspoint: buffers bytes, decodes the header
// destination, runs the request/grant handshake with that output's arbiter, streams the packet.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a head-of-FIFO header byte
// REQ     | request[dest] high, waiting for grant[dest]
// SEND    | granted; forwarding bytes until the last one is popped
// RELEASE | request dropped, waiting for the arbiter to withdraw grant
// DROP    | illegal destination; discarding bytes through the last one
module port_requester #(
  parameter int DATA_W     = 8,
  parameter int NUM_PORTS  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [NUM_PORTS-1:0] request,
  input  logic [NUM_PORTS-1:0] grant,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 grant_lost,
  output logic [CNT_W-1:0]     pkt_sent,
  output logic [CNT_W-1:0]     pkt_dropped
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SEND,
    S_RELEASE,
    S_DROP
  } state_t;

  // FIFO storage, entries are {last, data}
  logic [DATA_W:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            empty, full, push, pop;
  logic [DATA_W:0] head;
  logic [DATA_W-1:0] head_data;
  logic            head_last;
  logic [3:0]      head_dest;
  logic [4:0]      dest_ext;
  logic            dest_legal;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign in_ready  = ~full;
  assign push      = in_valid & ~full;
  assign head      = mem[rd_ptr];
  assign head_data = head[DATA_W-1:0];
  assign head_last = head[DATA_W];
  assign head_dest = head_data[3:0];
  assign dest_ext  = {1'b0, head_dest};
  assign dest_legal = (dest_ext < 5'(NUM_PORTS));

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {in_last, in_data};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Control state
  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] request_q, request_d;
  logic [PW-1:0]        dest_q, dest_d;
  logic                 grant_lost_q, grant_lost_d;
  logic [CNT_W-1:0]     sent_q, sent_d;
  logic [CNT_W-1:0]     dropped_q, dropped_d;
  logic                 grant_dest;

  assign grant_dest = grant[dest_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      request_q    <= '0;
      dest_q       <= '0;
      grant_lost_q <= 1'b0;
      sent_q       <= '0;
      dropped_q    <= '0;
    end else begin
      state_q      <= state_d;
      request_q    <= request_d;
      dest_q       <= dest_d;
      grant_lost_q <= grant_lost_d;
      sent_q       <= sent_d;
      dropped_q    <= dropped_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    request_d    = request_q;
    dest_d       = dest_q;
    grant_lost_d = grant_lost_q;
    sent_d       = sent_q;
    dropped_d    = dropped_q;
    pop          = 1'b0;
    out_valid    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          if (dest_legal) begin
            dest_d    = head_dest[PW-1:0];
            request_d = NUM_PORTS'(1) << head_dest[PW-1:0];
            state_d   = S_REQ;
          end else begin
            state_d   = S_DROP;
          end
        end
      end

      S_REQ: begin
        if (grant_dest) state_d = S_SEND;
      end

      S_SEND: begin
        if (!grant_dest) begin
          // Grant withdrawn under us: flag it and go back to waiting, request kept up.
          grant_lost_d = 1'b1;
          state_d      = S_REQ;
        end else if (!empty) begin
          out_valid = 1'b1;
          if (out_ready) begin
            pop = 1'b1;
            if (head_last) begin
              request_d = '0;
              sent_d    = sent_q + CNT_W'(1);
              state_d   = S_RELEASE;
            end
          end
        end
      end

      S_RELEASE: begin
        request_d = '0;
        if (!grant_dest) state_d = S_IDLE;
      end

      S_DROP: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_last) begin
            dropped_d = dropped_q + CNT_W'(1);
            state_d   = S_IDLE;
          end
        end
      end

      default: begin
        request_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign out_data    = (state_q == S_SEND) ? head_data : '0;
  assign out_last    = out_valid & head_last;
  assign request     = request_q;
  assign grant_lost  = grant_lost_q;
  assign pkt_sent    = sent_q;
  assign pkt_dropped = dropped_q;

endmodule
